// File: rtl/cpu_param.sv
// cpu_param: parametrised four-phase (fetch/exec/writeback/pc-update) CPU
// with loadable instruction memory, zero/carry flags, immediate load,
// conditional branches and a combinational debug read port into data memory.
module cpu_param #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 8,
    parameter  int PC_W   = 8,
    localparam int IW     = 4 + 2*ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_we,
    input  logic [PC_W-1:0]   imem_waddr,
    input  logic [IW-1:0]     imem_wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic              zflag,
    output logic              cflag
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_WB, S_PCUPD, S_HALT
    } state_t;

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JZ  = 4'd5;
    localparam logic [3:0] OP_JC  = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd8;

    state_t state, state_nx;

    logic [IW-1:0]     imem [2**PC_W];
    logic [DATA_W-1:0] dmem [2**ADDR_W];

    logic [IW-1:0]     ireg;
    logic [DATA_W-1:0] tmp;

    logic [3:0]        opc;
    logic [ADDR_W-1:0] op1, op2;
    logic [DATA_W-1:0] imm;
    logic [PC_W-1:0]   tgt;
    logic [PC_W-1:0]   pc_inc;

    logic [DATA_W-1:0] opa, opb, res;
    logic [DATA_W:0]   sum;
    logic              z_nx, c_nx;
    logic              wr_op;

    assign opc    = ireg[IW-1 -: 4];
    assign op1    = ireg[2*ADDR_W-1 -: ADDR_W];
    assign op2    = ireg[ADDR_W-1:0];
    assign pc_inc = pc + PC_W'(1);

    // Immediate is op2 zero-extended or truncated to the data width.
    if (DATA_W <= ADDR_W) begin : g_imm_trunc
        assign imm = op2[DATA_W-1:0];
    end else begin : g_imm_ext
        assign imm = {{(DATA_W-ADDR_W){1'b0}}, op2};
    end

    // Branch target is op1 fitted to the PC width.
    if (PC_W <= ADDR_W) begin : g_tgt_trunc
        assign tgt = op1[PC_W-1:0];
    end else begin : g_tgt_ext
        assign tgt = {{(PC_W-ADDR_W){1'b0}}, op1};
    end

    assign busy     = (state == S_FETCH) || (state == S_EXEC) ||
                      (state == S_WB)    || (state == S_PCUPD);
    assign halted   = (state == S_HALT);
    assign dbg_data = dmem[dbg_addr];

    // ALU: operands are read from dmem before any writeback of this op,
    // so op1==op2 sees the old value.
    always_comb begin
        opa   = dmem[op1];
        opb   = dmem[op2];
        sum   = {1'b0, opa} + {1'b0, opb};
        res   = '0;
        z_nx  = zflag;
        c_nx  = cflag;
        wr_op = 1'b0;
        case (opc)
            OP_MOV: begin
                res   = opb;
                wr_op = 1'b1;
            end
            OP_ADD: begin
                res   = sum[DATA_W-1:0];
                c_nx  = sum[DATA_W];
                z_nx  = (sum[DATA_W-1:0] == '0);
                wr_op = 1'b1;
            end
            OP_SUB: begin
                res   = opa - opb;
                c_nx  = (opa < opb);
                z_nx  = (opa == opb);
                wr_op = 1'b1;
            end
            OP_CMP: begin
                c_nx = (opa < opb);
                z_nx = (opa == opb);
            end
            OP_LDI: begin
                res   = imm;
                wr_op = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state sequencing of the instruction cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_EXEC;
            S_EXEC:  state_nx = S_WB;
            S_WB:    state_nx = S_PCUPD;
            S_PCUPD: state_nx = (opc == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  if (start) state_nx = S_FETCH;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Datapath registers: pc, instruction, result temp and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            ireg  <= '0;
            tmp   <= '0;
            zflag <= 1'b0;
            cflag <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc    <= '0;
                        zflag <= 1'b0;
                        cflag <= 1'b0;
                    end
                end
                S_FETCH: ireg <= imem[pc];
                S_EXEC: begin
                    tmp   <= res;
                    zflag <= z_nx;
                    cflag <= c_nx;
                end
                S_PCUPD: begin
                    case (opc)
                        OP_JMP:  pc <= tgt;
                        OP_JZ:   pc <= zflag ? tgt : pc_inc;
                        OP_JC:   pc <= cflag ? tgt : pc_inc;
                        OP_HLT:  pc <= pc;
                        default: pc <= pc_inc;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Data memory writeback; not reset. Reset forces IDLE asynchronously,
    // so an interrupted WB never reaches its write edge.
    always_ff @(posedge clk) begin
        if (state == S_WB && wr_op) dmem[op1] <= tmp;
    end

    // Instruction memory load port, only accepted while not executing.
    always_ff @(posedge clk) begin
        if (imem_we && (state == S_IDLE || state == S_HALT))
            imem[imem_waddr] <= imem_wdata;
    end

endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: scoreboard bench for cpu_param across three parameter sets.
module tb_cpu_param;

    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_CMP = 4'd3,
                           OP_JMP = 4'd4, OP_JZ = 4'd5, OP_LDI = 4'd7,
                           OP_HLT = 4'd8, OP_NOP = 4'd9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string tag;
        int    addr;
        int    exp;
    } sb_t;
    sb_t sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: default widths ----------------
    logic        rst_n_a, imem_we_a, start_a, busy_a, halted_a, zflag_a, cflag_a;
    logic [7:0]  imem_waddr_a, dbg_addr_a, dbg_data_a, pc_a;
    logic [19:0] imem_wdata_a;

    cpu_param u_a (
        .clk(clk), .rst_n(rst_n_a), .imem_we(imem_we_a), .imem_waddr(imem_waddr_a),
        .imem_wdata(imem_wdata_a), .start(start_a), .dbg_addr(dbg_addr_a),
        .dbg_data(dbg_data_a), .pc(pc_a), .busy(busy_a), .halted(halted_a),
        .zflag(zflag_a), .cflag(cflag_a)
    );

    // ---------------- instance B: PC_W=2 ----------------
    logic        rst_n_b, imem_we_b, start_b, busy_b, halted_b, zflag_b, cflag_b;
    logic [1:0]  imem_waddr_b, pc_b;
    logic [7:0]  dbg_addr_b, dbg_data_b;
    logic [19:0] imem_wdata_b;

    cpu_param #(.PC_W(2)) u_b (
        .clk(clk), .rst_n(rst_n_b), .imem_we(imem_we_b), .imem_waddr(imem_waddr_b),
        .imem_wdata(imem_wdata_b), .start(start_b), .dbg_addr(dbg_addr_b),
        .dbg_data(dbg_data_b), .pc(pc_b), .busy(busy_b), .halted(halted_b),
        .zflag(zflag_b), .cflag(cflag_b)
    );

    // ---------------- instance C: DATA_W=16, ADDR_W=10 ----------------
    logic        rst_n_c, imem_we_c, start_c, busy_c, halted_c, zflag_c, cflag_c;
    logic [7:0]  imem_waddr_c, pc_c;
    logic [9:0]  dbg_addr_c;
    logic [15:0] dbg_data_c;
    logic [23:0] imem_wdata_c;

    cpu_param #(.DATA_W(16), .ADDR_W(10)) u_c (
        .clk(clk), .rst_n(rst_n_c), .imem_we(imem_we_c), .imem_waddr(imem_waddr_c),
        .imem_wdata(imem_wdata_c), .start(start_c), .dbg_addr(dbg_addr_c),
        .dbg_data(dbg_data_c), .pc(pc_c), .busy(busy_c), .halted(halted_c),
        .zflag(zflag_c), .cflag(cflag_c)
    );

    function automatic logic [19:0] enc8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        return {op, x, y};
    endfunction

    task automatic load_a(input int addr, input logic [3:0] op, input int x, input int y);
        imem_we_a    = 1'b1;
        imem_waddr_a = addr[7:0];
        imem_wdata_a = enc8(op, x[7:0], y[7:0]);
        tick();
        imem_we_a    = 1'b0;
    endtask

    // Pulse start; the flags must read clear right after the start edge.
    task automatic start_a_pulse(input string tag);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk({tag, "_flags_clr"}, {30'd0, zflag_a, cflag_a}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_a}, 32'd1);
    endtask

    // Count edges after the start edge until halted, bounded.
    task automatic wait_halt_a(output int n);
        n = 0;
        while (!halted_a && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic drain_a();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            dbg_addr_a = e.addr[7:0];
            #1;
            chk(e.tag, {24'd0, dbg_data_a}, e.exp);
        end
    endtask

    initial begin
        int n;
        sb_t e;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        imem_we_a = 0; start_a = 0; imem_waddr_a = 0; imem_wdata_a = 0; dbg_addr_a = 0;
        imem_we_b = 0; start_b = 0; imem_waddr_b = 0; imem_wdata_b = 0; dbg_addr_b = 0;
        imem_we_c = 0; start_c = 0; imem_waddr_c = 0; imem_wdata_c = 0; dbg_addr_c = 0;
        tick(); tick();
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;
        tick();

        // Reset state
        chk("rst_pc",     {24'd0, pc_a},      0);
        chk("rst_busy",   {31'd0, busy_a},    0);
        chk("rst_halted", {31'd0, halted_a},  0);
        chk("rst_z",      {31'd0, zflag_a},   0);
        chk("rst_c",      {31'd0, cflag_a},   0);

        // Basic arithmetic: 200+100 = 300 mod 256 = 44, carry out
        load_a(0, OP_LDI, 1, 200);
        load_a(1, OP_LDI, 2, 100);
        load_a(2, OP_ADD, 1, 2);
        load_a(3, OP_HLT, 0, 0);
        sb_q.push_back('{"arith_d1", 1, 44});
        sb_q.push_back('{"arith_d2", 2, 100});
        start_a_pulse("arith");
        wait_halt_a(n);
        chk("arith_cycles", n, 16);
        chk("arith_pc", {24'd0, pc_a}, 3);
        chk("arith_c", {31'd0, cflag_a}, 1);
        chk("arith_z", {31'd0, zflag_a}, 0);
        chk("arith_busy_low", {31'd0, busy_a}, 0);
        drain_a();

        // Borrow and zero: 5-7 = 254 with borrow, then x-x = 0
        load_a(0, OP_LDI, 3, 5);
        load_a(1, OP_LDI, 4, 7);
        load_a(2, OP_SUB, 3, 4);
        load_a(3, OP_SUB, 4, 4);
        load_a(4, OP_HLT, 0, 0);
        sb_q.push_back('{"borrow_d3", 3, 254});
        sb_q.push_back('{"borrow_d4", 4, 0});
        start_a_pulse("borrow");
        wait_halt_a(n);
        chk("borrow_cycles", n, 20);
        chk("borrow_c", {31'd0, cflag_a}, 0);
        chk("borrow_z", {31'd0, zflag_a}, 1);
        drain_a();

        // Countdown loop: 3 LDIs, two full passes (SUB,CMP,JZ,JMP),
        // a final pass that exits at JZ (SUB,CMP,JZ), then HLT:
        // 3 + 4 + 4 + 3 + 1 = 15 instructions = 60 clocks.
        load_a(0, OP_LDI, 0, 3);
        load_a(1, OP_LDI, 1, 1);
        load_a(2, OP_LDI, 2, 0);
        load_a(3, OP_SUB, 0, 1);
        load_a(4, OP_CMP, 0, 2);
        load_a(5, OP_JZ, 7, 0);
        load_a(6, OP_JMP, 3, 0);
        load_a(7, OP_HLT, 0, 0);
        sb_q.push_back('{"loop_d0", 0, 0});
        start_a_pulse("loop");
        wait_halt_a(n);
        chk("loop_cycles", n, 60);
        chk("loop_pc", {24'd0, pc_a}, 7);
        drain_a();

        // Busy guards: imem write and start pulses during execution are ignored
        load_a(0, OP_LDI, 6, 11);
        load_a(1, OP_LDI, 6, 22);
        load_a(2, OP_HLT, 0, 0);
        sb_q.push_back('{"guard_d6", 6, 22});
        start_a_pulse("guard");
        imem_we_a = 1'b1; imem_waddr_a = 8'd1; imem_wdata_a = enc8(OP_LDI, 8'd6, 8'd33);
        tick();
        imem_we_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_halt_a(n);
        chk("guard_cycles", n + 2, 12);
        chk("guard_pc", {24'd0, pc_a}, 2);
        drain_a();

        // Reset during WB of LDI 5,9 (pc=1), dmem[5] previously 1
        load_a(0, OP_LDI, 5, 1);
        load_a(1, OP_HLT, 0, 0);
        start_a_pulse("pre_rst");
        wait_halt_a(n);
        load_a(0, OP_NOP, 0, 0);
        load_a(1, OP_LDI, 5, 9);
        load_a(2, OP_HLT, 0, 0);
        start_a_pulse("midrst");
        repeat (4) tick();
        chk("midrst_pc_before", {24'd0, pc_a}, 1);
        tick(); tick();            // FETCH and EXEC edges: now in WB
        rst_n_a = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy_a}, 0);
        tick();                    // the would-be WB edge, still in reset
        chk("midrst_pc", {24'd0, pc_a}, 0);
        chk("midrst_halted", {31'd0, halted_a}, 0);
        sb_q.push_back('{"midrst_d5", 5, 1});
        drain_a();
        rst_n_a = 1'b1;

        // PC wrap on PC_W=2: four NOPs, pc 0,1,2,3,0 and never halts
        for (int i = 0; i < 4; i++) begin
            imem_we_b = 1'b1; imem_waddr_b = i[1:0]; imem_wdata_b = enc8(OP_NOP, 8'd0, 8'd0);
            tick();
        end
        imem_we_b = 1'b0;
        for (int i = 0; i < 5; i++) sb_q.push_back('{"wrap_pc", -1, i % 4});
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, {30'd0, pc_b}, e.exp);
            chk("wrap_nohalt", {31'd0, halted_b}, 0);
            repeat (4) tick();
        end

        // Wide data: LDI 1000,1023; ADD 1000,1000 -> 2046, no carry
        imem_we_c = 1'b1;
        imem_waddr_c = 8'd0; imem_wdata_c = {OP_LDI, 10'd1000, 10'd1023}; tick();
        imem_waddr_c = 8'd1; imem_wdata_c = {OP_ADD, 10'd1000, 10'd1000}; tick();
        imem_waddr_c = 8'd2; imem_wdata_c = {OP_HLT, 10'd0, 10'd0};       tick();
        imem_we_c = 1'b0;
        sb_q.push_back('{"wide_d1000", 1000, 2046});
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        n = 0;
        while (!halted_c && n < 400) begin
            tick();
            n++;
        end
        chk("wide_cycles", n, 12);
        chk("wide_c", {31'd0, cflag_c}, 0);
        chk("wide_z", {31'd0, zflag_c}, 0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            dbg_addr_c = e.addr[9:0];
            #1;
            chk(e.tag, {16'd0, dbg_data_c}, e.exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
